// File: rtl/logic_diag_pkg.sv
// Shared types and constants for the logic-diagram sweep engine.
// The golden table is bit v = z for vector v = {x1,x2,x3,x4}.
package logic_diag_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;

  localparam logic [NUM_VEC-1:0] LOGIC_DIAG2_TT = 16'hA080;
  localparam logic [VEC_W-1:0]   LAST_VEC       = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that holds a vector stable for CYCLES clocks.
// Loaded with CYCLES-1 on entry to SETTLE, so expired is high on the last settle cycle.
module sweep_settle_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/logic_diag_sweeper.sv
// Exhaustive 16-vector stimulus/response engine for a 4-input logic-diagram block:
// drives x1..x4, samples z after a settle time, builds the truth table and scores it.
module logic_diag_sweeper
  import logic_diag_pkg::*;
#(
  parameter int unsigned        SETTLE_CYCLES = 1,
  parameter logic [NUM_VEC-1:0] EXPECTED      = LOGIC_DIAG2_TT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             z,
  output logic             x1,
  output logic             x2,
  output logic             x3,
  output logic             x4,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NUM_VEC-1:0] truth_table,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_index
);

  sweep_state_e r_state;
  sweep_state_e w_next_state;

  logic [VEC_W-1:0]   r_vec;
  logic               r_busy;
  logic               r_pass;
  logic [NUM_VEC-1:0] r_truth_table;
  logic               r_fail_valid;
  logic [VEC_W-1:0]   r_fail_index;

  logic               w_timer_load;
  logic               w_timer_en;
  logic               w_timer_expired;
  logic               w_last_vec;
  logic               w_mismatch;
  logic [NUM_VEC-1:0] w_tt_next;

  sweep_settle_timer #(
    .CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_en     (w_timer_en),
    .o_expired(w_timer_expired)
  );

  assign w_last_vec = (r_vec == LAST_VEC);
  assign w_mismatch = (z != EXPECTED[r_vec]);

  // Table as it will be after this SAMPLE cycle; lets pass see the vector-15 sample.
  always_comb begin
    w_tt_next        = r_truth_table;
    w_tt_next[r_vec] = z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SETTLE;
          w_timer_load = 1'b1;
        end
      end
      SETTLE: begin
        w_timer_en = 1'b1;
        if (w_timer_expired) begin
          w_next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        if (w_last_vec) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SETTLE;
          w_timer_load = 1'b1;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // NOTE: the truth table is a flop vector, not a RAM, so it is reset with the rest of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec         <= '0;
      r_busy        <= 1'b0;
      r_pass        <= 1'b0;
      r_truth_table <= '0;
      r_fail_valid  <= 1'b0;
      r_fail_index  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_vec         <= '0;
            r_busy        <= 1'b1;
            r_pass        <= 1'b0;
            r_truth_table <= '0;
            r_fail_valid  <= 1'b0;
            r_fail_index  <= '0;
          end
        end
        SAMPLE: begin
          r_truth_table <= w_tt_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_index <= r_vec;
          end
          if (w_last_vec) begin
            r_pass <= (w_tt_next == EXPECTED);
          end else begin
            r_vec <= r_vec + VEC_W'(1);
          end
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign {x1, x2, x3, x4} = r_vec;
  assign busy             = r_busy;
  assign done             = (r_state == DONE);
  assign pass             = r_pass;
  assign truth_table      = r_truth_table;
  assign fail_valid       = r_fail_valid;
  assign fail_index       = r_fail_index;

endmodule

// File: tb/tb_logic_diag_sweeper.sv
// Self-checking bench: two sweepers (settle 1 and settle 3) looped back through
// table-driven responders, scored against a vector-level reference model.
module tb_logic_diag_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] gold = 16'hA080;

  // Instance A: SETTLE_CYCLES=1
  logic        start_a = 1'b0;
  logic        z_a;
  logic        x1_a, x2_a, x3_a, x4_a;
  logic        busy_a, done_a, pass_a, fv_a;
  logic [15:0] tt_a;
  logic [3:0]  fi_a;
  logic [15:0] resp_a = 16'h0000;

  // Instance B: SETTLE_CYCLES=3
  logic        start_b = 1'b0;
  logic        z_b;
  logic        x1_b, x2_b, x3_b, x4_b;
  logic        busy_b, done_b, pass_b, fv_b;
  logic [15:0] tt_b;
  logic [3:0]  fi_b;
  logic [15:0] resp_b = 16'h0000;

  assign z_a = resp_a[{x1_a, x2_a, x3_a, x4_a}];
  assign z_b = resp_b[{x1_b, x2_b, x3_b, x4_b}];

  logic_diag_sweeper #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .z(z_a),
    .x1(x1_a), .x2(x2_a), .x3(x3_a), .x4(x4_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .truth_table(tt_a),
    .fail_valid(fv_a), .fail_index(fi_a)
  );

  logic_diag_sweeper #(.SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .z(z_b),
    .x1(x1_b), .x2(x2_b), .x3(x3_b), .x4(x4_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .truth_table(tt_b),
    .fail_valid(fv_b), .fail_index(fi_b)
  );

  int sel = 0;
  logic        s_busy, s_done, s_pass, s_fv;
  logic [15:0] s_tt;
  logic [3:0]  s_fi, s_x;

  always_comb begin
    if (sel == 0) begin
      s_busy = busy_a; s_done = done_a; s_pass = pass_a; s_fv = fv_a;
      s_tt   = tt_a;   s_fi   = fi_a;   s_x    = {x1_a, x2_a, x3_a, x4_a};
    end else begin
      s_busy = busy_b; s_done = done_b; s_pass = pass_b; s_fv = fv_b;
      s_tt   = tt_b;   s_fi   = fi_b;   s_x    = {x1_b, x2_b, x3_b, x4_b};
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  // First vector (sweep order) whose response disagrees with the golden table.
  function automatic logic [3:0] first_diff(input logic [15:0] tbl, input logic [15:0] ref_tbl);
    for (int v = 0; v < 16; v++) begin
      if (tbl[v] != ref_tbl[v]) return v[3:0];
    end
    return 4'd0;
  endfunction

  task automatic drive_start(input int d, input logic v);
    if (d == 0) start_a = v;
    else        start_b = v;
  endtask

  // One full sweep on instance d with responder table tbl; optionally re-pulses start
  // at cycles 5, 20 and on the done cycle. Cycle 1 is the first cycle after acceptance.
  task automatic run_sweep(input int d, input logic [15:0] tbl, input bit disturb, input string tag);
    int          per;
    int          done_cyc;
    logic [3:0]  exp_x;
    logic        exp_busy, exp_done, exp_pass, exp_fv;
    logic [3:0]  exp_fi;

    per      = (d == 0) ? 2 : 4;
    done_cyc = 16 * per + 1;
    exp_pass = (tbl == gold);
    exp_fv   = !exp_pass;
    exp_fi   = exp_fv ? first_diff(tbl, gold) : 4'd0;

    sel = d;
    if (d == 0) resp_a = tbl;
    else        resp_b = tbl;

    @(negedge clk);
    drive_start(d, 1'b1);
    @(negedge clk);
    drive_start(d, 1'b0);

    for (int c = 1; c <= done_cyc + 3; c++) begin
      if (c > 1) @(negedge clk);
      exp_x    = (c > 16 * per) ? 4'd15 : 4'((c - 1) / per);
      exp_busy = (c <= done_cyc);
      exp_done = (c == done_cyc);

      vectors++;
      if (s_x !== exp_x) begin
        miscompares++;
        $display("FAIL %s x cycle %0d: got %h want %h", tag, c, s_x, exp_x);
      end
      vectors++;
      if (s_busy !== exp_busy) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: got %b want %b", tag, c, s_busy, exp_busy);
      end
      vectors++;
      if (s_done !== exp_done) begin
        miscompares++;
        $display("FAIL %s done cycle %0d: got %b want %b", tag, c, s_done, exp_done);
      end
      if (c >= done_cyc) begin
        vectors++;
        if (s_tt !== tbl) begin
          miscompares++;
          $display("FAIL %s truth_table cycle %0d: got %h want %h", tag, c, s_tt, tbl);
        end
        vectors++;
        if (s_pass !== exp_pass) begin
          miscompares++;
          $display("FAIL %s pass cycle %0d: got %b want %b", tag, c, s_pass, exp_pass);
        end
        vectors++;
        if (s_fv !== exp_fv) begin
          miscompares++;
          $display("FAIL %s fail_valid cycle %0d: got %b want %b", tag, c, s_fv, exp_fv);
        end
        if (exp_fv) begin
          vectors++;
          if (s_fi !== exp_fi) begin
            miscompares++;
            $display("FAIL %s fail_index cycle %0d: got %0d want %0d", tag, c, s_fi, exp_fi);
          end
        end
      end
      drive_start(d, disturb && (c == 5 || c == 20 || c == done_cyc));
    end
    drive_start(d, 1'b0);
  endtask

  task automatic check_reset_values(input int d, input string tag);
    sel = d;
    #1;
    vectors++;
    if ({s_x, s_busy, s_done, s_pass, s_fv, s_fi} !== 12'h000 || s_tt !== 16'h0000) begin
      miscompares++;
      $display("FAIL %s: got x=%h busy=%b done=%b pass=%b fv=%b fi=%h tt=%h want all zero",
               tag, s_x, s_busy, s_done, s_pass, s_fv, s_fi, s_tt);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values(0, "reset_a");
    check_reset_values(1, "reset_b");
    rst = 1'b0;
  endtask

  task automatic test_loopback;
    run_sweep(0, gold, 1'b0, "loopback");
  endtask

  task automatic test_z_tied;
    run_sweep(0, 16'h0000, 1'b0, "z_tied0");
    run_sweep(0, 16'hFFFF, 1'b0, "z_tied1");
  endtask

  task automatic test_last_vector;
    run_sweep(0, gold ^ 16'h8000, 1'b0, "vec15_only");
  endtask

  task automatic test_start_ignored;
    run_sweep(0, gold, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_midsweep;
    sel    = 0;
    resp_a = 16'hFFFF;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values(0, "reset_midsweep");
    rst = 1'b0;
    run_sweep(0, gold, 1'b0, "after_reset");
  endtask

  task automatic test_settle3;
    run_sweep(1, gold, 1'b0, "settle3");
    run_sweep(1, 16'h0000, 1'b1, "settle3_z0");
  endtask

  task automatic test_random;
    logic [15:0] tbl;
    int          d;
    for (int i = 0; i < 6; i++) begin
      tbl = 16'($urandom);
      if (i == 0) tbl = gold ^ (16'h1 << $urandom_range(0, 15));
      d = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(d, tbl, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_z_tied();
    test_last_vector();
    test_start_ignored();
    test_reset_midsweep();
    test_settle3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
